// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the multicycle control unit:
// FSM states, opcodes, mux/ALU codes and the control vector.
package controle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADDR  = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        RWB      = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11,
        HALT     = 4'd12
    } estado_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_SHL = 2'b11;

    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_OUT = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic retira(input estado_t s);
        return (s == MEMWB) || (s == MEMWRITE) || (s == RWB) ||
               (s == BRANCH) || (s == JUMP) || (s == ADDI_WB);
    endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Datapath control bundle driven by the control unit.
// master = control unit, slave = datapath.
interface controle_if;

    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_en;

    modport master (
        output pc_write, pc_write_cond, iord, mem_read,
        output mem_write, ir_write, mem_to_reg, reg_dst,
        output reg_write, alu_src_a, alu_src_b, alu_op,
        output pc_source, pc_en
    );

    modport slave (
        input pc_write, pc_write_cond, iord, mem_read,
        input mem_write, ir_write, mem_to_reg, reg_dst,
        input reg_write, alu_src_a, alu_src_b, alu_op,
        input pc_source, pc_en
    );

endinterface

// File: rtl/controle_multiciclo_saidas.sv
// Moore output decoder: current state to datapath control vector.
module controle_saidas
    import controle_pkg::*;
(
    input  estado_t estado,
    output ctrl_t   ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (estado)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCS_ALU;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_SHL;
            end
            MEMADDR, ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.pc_write_cond = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_source     = PCS_OUT;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JMP;
            end
            ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit: state register, dispatch,
// reset-gated control outputs and performance counters.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int COUNT_W      = 32,
    parameter bit HALT_ON_ZERO = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        instrucao,
    input  logic               zero,
    controle_if.master         ctl,
    output logic               halted,
    output logic               illegal,
    output logic [3:0]         estado,
    output logic [COUNT_W-1:0] ciclos,
    output logic [COUNT_W-1:0] instrucoes
);

    estado_t    st, nx;
    ctrl_t      c, g;
    logic       ilegal_d;
    logic [5:0] opcode;

    assign opcode = instrucao[31:26];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) st <= FETCH;
        else        st <= nx;
    end

    always_comb begin
        nx       = st;
        ilegal_d = 1'b0;
        unique case (st)
            FETCH:  nx = DECODE;
            DECODE: begin
                if (HALT_ON_ZERO && instrucao == 32'd0) begin
                    nx = HALT;
                end else begin
                    unique case (opcode)
                        OP_R:         nx = EXEC_R;
                        OP_LW, OP_SW: nx = MEMADDR;
                        OP_BEQ:       nx = BRANCH;
                        OP_J:         nx = JUMP;
                        OP_ADDI:      nx = ADDI_EX;
                        default: begin
                            nx       = FETCH;
                            ilegal_d = 1'b1;
                        end
                    endcase
                end
            end
            MEMADDR: nx = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD: nx = MEMWB;
            EXEC_R:  nx = RWB;
            ADDI_EX: nx = ADDI_WB;
            MEMWB, MEMWRITE, RWB,
            BRANCH, JUMP, ADDI_WB: nx = FETCH;
            HALT:    nx = HALT;
            default: nx = FETCH;
        endcase
    end

    controle_saidas u_saidas (
        .estado (st),
        .ctrl   (c)
    );

    // Reset low kills every enable without waiting for a clock edge
    assign g = reset ? c : '0;

    assign ctl.pc_write      = g.pc_write;
    assign ctl.pc_write_cond = g.pc_write_cond;
    assign ctl.iord          = g.iord;
    assign ctl.mem_read      = g.mem_read;
    assign ctl.mem_write     = g.mem_write;
    assign ctl.ir_write      = g.ir_write;
    assign ctl.mem_to_reg    = g.mem_to_reg;
    assign ctl.reg_dst       = g.reg_dst;
    assign ctl.reg_write     = g.reg_write;
    assign ctl.alu_src_a     = g.alu_src_a;
    assign ctl.alu_src_b     = g.alu_src_b;
    assign ctl.alu_op        = g.alu_op;
    assign ctl.pc_source     = g.pc_source;
    assign ctl.pc_en         = g.pc_write | (g.pc_write_cond & zero);

    assign halted  = reset & (st == HALT);
    assign illegal = reset & ilegal_d;
    assign estado  = st;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ciclos     <= '0;
            instrucoes <= '0;
        end else begin
            if (st != HALT) ciclos <= ciclos + 1'b1;
            if (retira(st)) instrucoes <= instrucoes + 1'b1;
        end
    end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle control unit sequencing the processor datapath (PC, instruction memory/IR, register file, ALU, data memory) of the `main2`-class core. It is a Moore FSM that walks each instruction through fetch/decode/execute/memory/write-back, drives every datapath enable and mux select, and stops the core permanently on the all-zero end-of-program instruction. It also keeps cycle and retired-instruction counters that the bench prints after each instruction.

## Interface
- `COUNT_W`, 32: width of both performance counters.
- `HALT_ON_ZERO`, 1: when 1, an all-zero instruction enters HALT. When 0, it executes as an R-type no-op.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `instrucao`  in  32  IR contents; opcode = [31:26], funct = [5:0].
- `zero`  in  1  ALU zero flag.
- `pc_write`, `pc_write_cond`, `iord`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each  datapath enables and selects.
- `alu_src_b`  out  2  ALU B-input select: 00 = reg B, 01 = +4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- `alu_op`  out  2  ALU op class: 00 = add, 01 = sub, 10 = funct-decoded.
- `pc_source`  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `pc_en`  out  1  = `pc_write | (pc_write_cond & zero)`.
- `halted`  out  1  sticky halt flag.
- `illegal`  out  1  one-cycle pulse on an unknown opcode.
- `estado`  out  4  current state, for debug.
- `ciclos`  out  COUNT_W  cycles since reset, excluding cycles in HALT.
- `instrucoes`  out  COUNT_W  retired instructions.

## Operation
- States, with encoding:
  - FETCH = 0
  - DECODE = 1
  - MEMADDR = 2
  - MEMREAD = 3
  - MEMWB = 4
  - MEMWRITE = 5
  - EXEC_R = 6
  - RWB = 7
  - BRANCH = 8
  - JUMP = 9
  - ADDI_EX = 10
  - ADDI_WB = 11
  - HALT = 12
- Transitions:
  - FETCH → DECODE.
  - DECODE dispatches on opcode:
    - `instrucao == 0` and `HALT_ON_ZERO` = 1 → HALT.
    - 0x00 → EXEC_R.
    - 0x23 (lw) or 0x2B (sw) → MEMADDR.
    - 0x04 (beq) → BRANCH.
    - 0x02 (j) → JUMP.
    - 0x08 (addi) → ADDI_EX.
    - any other opcode → FETCH, with `illegal` = 1 during that DECODE cycle.
  - MEMADDR → MEMREAD for lw, → MEMWRITE for sw.
  - MEMREAD → MEMWB.
  - EXEC_R → RWB.
  - ADDI_EX → ADDI_WB.
  - MEMWB, MEMWRITE, RWB, BRANCH, JUMP and ADDI_WB → FETCH.
  - HALT → HALT.
- Outputs (every signal not listed is 0):
  - FETCH: `mem_read`, `ir_write`, `pc_write`; `alu_src_b` = 01.
  - DECODE: `alu_src_b` = 11.
  - MEMADDR and ADDI_EX: `alu_src_a`; `alu_src_b` = 10.
  - MEMREAD: `mem_read`, `iord`.
  - MEMWB: `reg_write`, `mem_to_reg`.
  - MEMWRITE: `mem_write`, `iord`.
  - EXEC_R: `alu_src_a`; `alu_op` = 10.
  - RWB: `reg_write`, `reg_dst`.
  - BRANCH: `alu_src_a`, `pc_write_cond`; `alu_op` = 01; `pc_source` = 01.
  - JUMP: `pc_write`; `pc_source` = 10.
  - ADDI_WB: `reg_write`.
  - HALT: all zero; `halted` = 1.
- `instrucoes` increments on the last cycle of each instruction: MEMWB, MEMWRITE, RWB, BRANCH, JUMP, ADDI_WB. An illegal-opcode DECODE does not retire.
- `ciclos` increments every non-HALT cycle and wraps modulo 2^COUNT_W. `instrucoes` also wraps.

## Timing
- Reset low forces, asynchronously:
  - `estado` = FETCH; `ciclos` = 0, `instrucoes` = 0.
  - `halted` = 0, `illegal` = 0.
  - Every enable is gated to 0 while reset is low, so no write reaches the datapath.
- The first rising edge after reset is released completes FETCH.
- Instruction latencies in cycles, counted from entering FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- HALT is entered at the end of DECODE, i.e. 2 cycles after the zero word's FETCH. `halted` rises in that same edge.
- The counters do not include the halting instruction.
- Reset asserted mid-instruction aborts it immediately. No partial write-back occurs, because enables drop asynchronously. That instruction is not counted.
- `zero` is sampled only through `pc_en`, combinationally, in BRANCH.

## Structure
- Package `controle_pkg` holds:
  - the state encoding constants;
  - the opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - the `alu_op`, `alu_src_b` and `pc_source` codes.
- One natural sub-module, `controle_saidas`: a purely combinational state-to-control-vector decoder.
- The top level holds the state register, next-state logic, counters and reset gating.

## Test plan
- Reset release, then `instrucao` = 0x00221820 (add) → `estado` sequence 0,1,6,7,0; `reg_write` and `reg_dst` high only in RWB; `instrucoes` = 1, `ciclos` = 4.
- lw 0x8C220004 then sw 0xAC220008 → lw state sequence 0,1,2,3,4 and sw sequence 0,1,2,5; `mem_write` pulses once; `instrucoes` = 2, `ciclos` = 9.
- beq 0x10220003 with `zero` = 1, then the same with `zero` = 0 → `pc_en` high in BRANCH only when `zero` = 1; 3 cycles each.
- Opcode 0x3F → `illegal` pulses for 1 cycle in DECODE; return to FETCH; `instrucoes` unchanged.
- `instrucao` = 0 → HALT after 2 cycles; `halted` = 1; all enables 0; `ciclos` frozen for 10 further cycles.
- Reset asserted during MEMREAD → `estado` = 0 and all outputs 0 immediately, with no clock edge; counters = 0.
